// File: rtl/inst_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inst_enc_pkg
//  Purpose  : Format codes, NOP word, immediate limits and FIFO entry type
//             shared by the RV32I instruction encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package inst_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int BIMM_MIN  = -4096;
    localparam int BIMM_MAX  = 4094;
    localparam int JIMM_MIN  = -1048576;
    localparam int JIMM_MAX  = 1048574;

    typedef struct packed {
        logic        err;
        logic [31:0] addr;
        logic [31:0] inst;
    } enc_entry_t;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input int                 lo,
                                      input int                 hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : enc_fifo
//  Purpose  : Synchronous FIFO holding encoded entries, with synchronous flush.
//  Revision : 1.0 - initial release
// ============================================================================
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    c_ptr_one = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty  = (r_wptr == r_rptr);
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;
    assign rdata  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_encoder
//  Purpose  : Packs RV32I fields and a 32-bit immediate into instruction words,
//             tags each with an imem byte address and queues it for writing.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    localparam int c_entry_w = $bits(enc_entry_t);

    logic signed [31:0] w_simm;
    logic [31:0]        w_enc;
    logic               w_bad;
    logic [31:0]        w_inst;
    logic               w_accept;
    logic               w_full;
    logic               w_empty;
    enc_entry_t         w_wentry;
    enc_entry_t         w_head;
    logic [31:0]        r_addr;
    logic [7:0]         r_err_cnt;

    assign w_simm = imm;

    always_comb begin
        w_enc = NOP_INST;
        w_bad = 1'b0;
        case (fmt)
            FMT_R: w_enc = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                w_enc = {imm[11:0], rs1, funct3, rd, opcode};
                w_bad = !in_range(w_simm, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_bad = !in_range(w_simm, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                w_enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_bad = !in_range(w_simm, BIMM_MIN, BIMM_MAX) || imm[0];
            end
            FMT_U: begin
                w_enc = {imm[31:12], rd, opcode};
                w_bad = (imm[11:0] != 12'h000);
            end
            FMT_J: begin
                w_enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_bad = !in_range(w_simm, JIMM_MIN, JIMM_MAX) || imm[0];
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign w_inst = w_bad ? NOP_INST : w_enc;

    // restart wins over a simultaneous accept; nothing is pushed that cycle.
    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready && !restart;

    assign w_wentry = '{err: w_bad, addr: r_addr, inst: w_inst};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= BASE_ADDR;
            r_err_cnt <= 8'd0;
        end else if (restart) begin
            r_addr    <= BASE_ADDR;
        end else if (w_accept) begin
            r_addr <= r_addr + 32'd4;
            if (w_bad && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .pop   (out_valid && out_ready),
        .flush (restart),
        .wdata (w_wentry),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_inst  = out_valid ? w_head.inst : 32'h0;
    assign out_addr  = out_valid ? w_head.addr : 32'h0;
    assign out_err   = out_valid ? w_head.err  : 1'b0;
    assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_encoder
//  Purpose  : Self-checking bench for inst_encoder against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_inst_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst, restart, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_inst, out_addr;
    logic [7:0]  err_count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_addr;
    int          m_errcnt;
    int          edges [14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095,
                                4096, -1048577, -1048576, 1048574, 1048575, 1048576};

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
    );

    function automatic longint fld(input longint x, input int hi, input int lo);
        return (x >> lo) & ((64'sd1 <<< (hi - lo + 1)) - 1);
    endfunction

    // Reference encoder: field placement by shifts, legality by integer ranges.
    function automatic void ref_encode(output logic [31:0] w, output bit bad);
        longint v   = longint'($signed(imm));
        longint ops = longint'(opcode);
        longint rdf = longint'(rd) << 7;
        longint f3  = longint'(funct3) << 12;
        longint r1  = longint'(rs1) << 15;
        longint r2  = longint'(rs2) << 20;
        longint acc = 0;
        bad = 1'b0;
        case (fmt)
            3'd0: acc = (longint'(funct7) << 25) | r2 | r1 | f3 | rdf | ops;
            3'd1: begin
                bad = (v < -2048) || (v > 2047);
                acc = (fld(v, 11, 0) << 20) | r1 | f3 | rdf | ops;
            end
            3'd2: begin
                bad = (v < -2048) || (v > 2047);
                acc = (fld(v, 11, 5) << 25) | r2 | r1 | f3 | (fld(v, 4, 0) << 7) | ops;
            end
            3'd3: begin
                bad = (v < -4096) || (v > 4094) || (v % 2 != 0);
                acc = (fld(v, 12, 12) << 31) | (fld(v, 10, 5) << 25) | r2 | r1 | f3 |
                      (fld(v, 4, 1) << 8) | (fld(v, 11, 11) << 7) | ops;
            end
            3'd4: begin
                bad = (fld(v, 11, 0) != 0);
                acc = (fld(v, 31, 12) << 12) | rdf | ops;
            end
            3'd5: begin
                bad = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
                acc = (fld(v, 20, 20) << 31) | (fld(v, 10, 1) << 21) | (fld(v, 11, 11) << 20) |
                      (fld(v, 19, 12) << 12) | rdf | ops;
            end
            default: bad = 1'b1;
        endcase
        w = bad ? 32'h0000_0013 : acc[31:0];
    endfunction

    task automatic set_f(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic rand_fields();
        int k;
        fmt = 3'($urandom); opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
        rs2 = 5'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        case ($urandom_range(4, 0))
            0: imm = $urandom;
            1: begin k = int'($urandom_range(8400, 0)) - 4200; imm = k; end
            2: begin k = edges[$urandom_range(13, 0)]; imm = k; end
            3: imm = $urandom & 32'hFFFF_F000;
            default: begin
                k = int'($urandom_range(2097152, 0)) - 1048576;
                imm = k;
                if ($urandom_range(1, 0) == 1) imm[0] = 1'b0;
            end
        endcase
    endtask

    // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
    task automatic step(input bit iv, input bit ordy, input bit rs);
        bit          can_push = exp_q.size() < DEPTH;
        bit          has_head = exp_q.size() > 0;
        exp_t        e;
        logic [31:0] w;
        bit          bad;
        in_valid = iv; out_ready = ordy; restart = rs;
        ref_encode(w, bad);
        @(posedge clk);
        if (rs) begin
            exp_q.delete();
            m_addr = BASE;
        end else begin
            if (has_head && ordy) void'(exp_q.pop_front());
            if (iv && can_push) begin
                e.inst = w; e.addr = m_addr; e.err = bad;
                exp_q.push_back(e);
                m_addr = m_addr + 32'd4;
                if (bad && m_errcnt < 255) m_errcnt++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_f(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        exp_q.delete(); m_addr = BASE; m_errcnt = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0 || out_addr !== 32'h0 ||
            out_err !== 1'b0 || err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset: got v=%b rdy=%b inst=%h addr=%h err=%b cnt=%0d, want 0 1 0 0 0 0",
                     out_valid, in_ready, out_inst, out_addr, out_err, err_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] want_inst [4] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123452B7};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_f(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
                1: set_f(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
                2: set_f(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
                default: set_f(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
            endcase
            step(1'b1, 1'b1, 1'b0);
            n_vec++;
            if (out_valid !== 1'b1 || out_inst !== want_inst[i] || out_addr !== 32'(4 * i) || out_err !== 1'b0) begin
                n_bad++;
                $display("FAIL directed %0d: got v=%b inst=%h addr=%h err=%b, want 1 %h %h 0",
                         i, out_valid, out_inst, out_addr, out_err, want_inst[i], 32'(4 * i));
            end
        end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_errors();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_f(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
                1: set_f(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
                default: set_f(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
            endcase
            step(1'b1, 1'b1, 1'b0);
            n_vec++;
            if (out_valid !== 1'b1 || out_inst !== 32'h0000_0013 || out_err !== 1'b1 || out_addr !== exp_q[0].addr) begin
                n_bad++;
                $display("FAIL error_word %0d: got v=%b inst=%h err=%b addr=%h, want 1 00000013 1 %h",
                         i, out_valid, out_inst, out_err, out_addr, exp_q[0].addr);
            end
        end
        n_vec++;
        if (err_count !== 8'd3) begin
            n_bad++;
            $display("FAIL err_count: got %0d want 3", err_count);
        end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b1, 1'b1);
        set_f(3'd1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd100);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 1'b0);
            n_vec++;
            if (in_ready !== (k < 4)) begin
                n_bad++;
                $display("FAIL bp_in_ready after push %0d: got %b want %b", k, in_ready, (k < 4));
            end
        end
        n_vec++;
        if (out_addr !== 32'd0) begin
            n_bad++;
            $display("FAIL bp_head_first: got %h want 00000000", out_addr);
        end
        step(1'b1, 1'b1, 1'b0);
        n_vec++;
        if (in_ready !== 1'b1 || out_addr !== 32'd4) begin
            n_bad++;
            $display("FAIL bp_pop_when_full: got rdy=%b addr=%h want 1 00000004", in_ready, out_addr);
        end
        step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_refill: got in_ready=%b want 0", in_ready);
        end
        for (int j = 0; j < 4; j++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_addr !== 32'(4 * j + 4)) begin
                n_bad++;
                $display("FAIL bp_drain %0d: got v=%b addr=%h want 1 %h", j, out_valid, out_addr, 32'(4 * j + 4));
            end
            step(1'b0, 1'b1, 1'b0);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        exp_t ex;
        bit   exp_v;
        for (int i = 0; i < 300; i++) begin
            rand_fields();
            step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, $urandom_range(31, 0) == 0);
            exp_v = exp_q.size() > 0;
            if (exp_v) ex = exp_q[0];
            else ex = '{inst: 32'h0, addr: 32'h0, err: 1'b0};
            n_vec++;
            if (out_valid !== exp_v || out_inst !== ex.inst || out_addr !== ex.addr || out_err !== ex.err) begin
                n_bad++;
                $display("FAIL random_head cyc %0d: got v=%b inst=%h addr=%h err=%b want v=%b inst=%h addr=%h err=%b",
                         i, out_valid, out_inst, out_addr, out_err, exp_v, ex.inst, ex.addr, ex.err);
            end
            n_vec++;
            if (in_ready !== (exp_q.size() < DEPTH)) begin
                n_bad++;
                $display("FAIL random_in_ready cyc %0d: got %b want %b", i, in_ready, (exp_q.size() < DEPTH));
            end
            n_vec++;
            if (err_count !== 8'(m_errcnt)) begin
                n_bad++;
                $display("FAIL random_err_count cyc %0d: got %0d want %0d", i, err_count, m_errcnt);
            end
        end
        step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_saturation();
        set_f(3'd6, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 1'b0);
        n_vec++;
        if (err_count !== 8'd255 || err_count !== 8'(m_errcnt)) begin
            n_bad++;
            $display("FAIL err_saturate: got %0d want 255", err_count);
        end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        set_f(3'd0, 7'b0110011, 5'd2, 5'd3, 5'd4, 3'd0, 7'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_pre: got out_valid=%b want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_inst !== 32'h0 || err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL arst_clear: got v=%b rdy=%b inst=%h cnt=%0d want 0 1 0 0",
                     out_valid, in_ready, out_inst, err_count);
        end
        #1 rst = 1'b0;
        exp_q.delete(); m_addr = BASE; m_errcnt = 0;
        step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_addr !== BASE || out_inst !== exp_q[0].inst) begin
            n_bad++;
            $display("FAIL arst_next: got v=%b addr=%h inst=%h want 1 %h %h",
                     out_valid, out_addr, out_inst, BASE, exp_q[0].inst);
        end
    endtask

    task automatic test_restart();
        set_f(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        set_f(3'd1, 7'b0010011, 5'd7, 5'd8, 5'd0, 3'd1, 7'd0, 32'd12);
        step(1'b1, 1'b1, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || err_count !== 8'(m_errcnt)) begin
            n_bad++;
            $display("FAIL restart_flush: got v=%b cnt=%0d want 0 %0d", out_valid, err_count, m_errcnt);
        end
        step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_addr !== BASE || out_inst !== 32'h00C41393) begin
            n_bad++;
            $display("FAIL restart_next: got v=%b addr=%h inst=%h want 1 %h 00c41393",
                     out_valid, out_addr, out_inst, BASE);
        end
        step(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_nopush: got out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_random();
        test_saturation();
        test_async_reset();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end

endmodule
`default_nettype wire
